// File: rtl/ntt_basemul.sv
// ntt_basemul: Kyber MultiplyNTTs base-case multiplier, one degree-1 pair
// per cycle.
//
// For pair i it computes
//   (a0 + a1*X)(b0 + b1*X) mod (X^2 - gamma_i),   gamma_i = ROOT^(2*br7(i)+1) mod Q
// so that
//   c0 = a0*b0 + a1*b1*gamma_i  (mod Q)
//   c1 = a0*b1 + a1*b0          (mod Q)
//
// The datapath is a 3-stage pipeline that moves only when the output
// register is empty or being drained. There is one global advance enable:
//   adv = !out_valid || out_ready
// and in_ready is adv.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr                 synchronous flush of all stages and the pair counter
//   in_valid/in_ready   input handshake for a0, a1, b0, b1 (each < 2Q)
//   out_valid/out_ready output handshake for c0, c1 (canonical [0, Q-1])
//   out_idx, out_last   pair index of the current output; high for pair N/2-1
//   busy                any pipeline stage holds valid data
module ntt_basemul #(
  parameter int Q             = 3329,
  parameter int ROOT_OF_UNITY = 17,
  parameter int N             = 256,
  parameter int COEF_W        = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] a0,
  input  logic [COEF_W-1:0] a1,
  input  logic [COEF_W-1:0] b0,
  input  logic [COEF_W-1:0] b1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] c0,
  output logic [COEF_W-1:0] c1,
  output logic [6:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int PAIRS  = N / 2;
  localparam int PROD_W = 2 * COEF_W;
  localparam int SUM_W  = 2 * COEF_W + 1;

  localparam logic [COEF_W-1:0] Q_C      = COEF_W'(Q);
  localparam logic [PROD_W-1:0] Q_P      = PROD_W'(Q);
  localparam logic [SUM_W-1:0]  Q_S      = SUM_W'(Q);
  localparam logic [6:0]        LAST_IDX = 7'(PAIRS - 1);

  // ---------------------------------------------------------------------------
  // gamma ROM, computed at elaboration from ROOT_OF_UNITY.
  // ---------------------------------------------------------------------------
  function automatic int br7(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 7; k++) begin
      r = r | (((v >> k) & 1) << (6 - k));
    end
    return r;
  endfunction

  function automatic int gamma_of(input int i);
    int e;
    int r;
    e = 2 * br7(i) + 1;
    r = 1;
    for (int k = 0; k < e; k++) begin
      r = (r * ROOT_OF_UNITY) % Q;
    end
    return r;
  endfunction

  logic [COEF_W-1:0] gamma_rom [PAIRS];

  for (genvar g = 0; g < PAIRS; g++) begin : g_gamma
    localparam int GV = gamma_of(g);
    assign gamma_rom[g] = COEF_W'(GV);
  end

  // Inputs are below 2Q, so a single conditional subtract is a full reduction.
  function automatic logic [COEF_W-1:0] reduce_once(input logic [COEF_W-1:0] x);
    return (x >= Q_C) ? (x - Q_C) : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake / control
  // ---------------------------------------------------------------------------
  logic       adv;
  logic       v1;
  logic       v2;
  logic [6:0] pair_cnt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = v1 | v2 | out_valid;

  // ---------------------------------------------------------------------------
  // Stage 1 registers and products
  // ---------------------------------------------------------------------------
  logic [COEF_W-1:0] a0_s1;
  logic [COEF_W-1:0] a1_s1;
  logic [COEF_W-1:0] b0_s1;
  logic [COEF_W-1:0] b1_s1;
  logic [COEF_W-1:0] gamma_s1;
  logic [6:0]        idx_s1;

  logic [PROD_W-1:0] p00;
  logic [PROD_W-1:0] p11;
  logic [PROD_W-1:0] p01;
  logic [PROD_W-1:0] p10;
  logic [COEF_W-1:0] p11_mod;
  logic [SUM_W-1:0]  sum1_s1;

  assign p00     = PROD_W'(a0_s1) * PROD_W'(b0_s1);
  assign p11     = PROD_W'(a1_s1) * PROD_W'(b1_s1);
  assign p01     = PROD_W'(a0_s1) * PROD_W'(b1_s1);
  assign p10     = PROD_W'(a1_s1) * PROD_W'(b0_s1);
  assign p11_mod = COEF_W'(p11 % Q_P);
  // Two products below Q^2 each: the sum needs 25 bits.
  assign sum1_s1 = SUM_W'(p01) + SUM_W'(p10);

  // ---------------------------------------------------------------------------
  // Stage 2 registers and the gamma term
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] p00_s2;
  logic [COEF_W-1:0] p11m_s2;
  logic [SUM_W-1:0]  sum1_s2;
  logic [COEF_W-1:0] gamma_s2;
  logic [6:0]        idx_s2;

  logic [PROD_W-1:0] t_prod;
  logic [COEF_W-1:0] t_mod;
  logic [SUM_W-1:0]  sum0_s2;
  logic [COEF_W-1:0] c0_next;
  logic [COEF_W-1:0] c1_next;

  assign t_prod  = PROD_W'(p11m_s2) * PROD_W'(gamma_s2);
  assign t_mod   = COEF_W'(t_prod % Q_P);
  assign sum0_s2 = SUM_W'(p00_s2) + SUM_W'(t_mod);
  assign c0_next = COEF_W'(sum0_s2 % Q_S);
  assign c1_next = COEF_W'(sum1_s2 % Q_S);

  // ---------------------------------------------------------------------------
  // Pipeline sequencing. clr wins over a same-cycle input handshake; the
  // output data registers are left as they are because out_valid drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a0_s1     <= '0;
      a1_s1     <= '0;
      b0_s1     <= '0;
      b1_s1     <= '0;
      gamma_s1  <= '0;
      idx_s1    <= '0;
      p00_s2    <= '0;
      p11m_s2   <= '0;
      sum1_s2   <= '0;
      gamma_s2  <= '0;
      idx_s2    <= '0;
      c0        <= '0;
      c1        <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      pair_cnt  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a0_s1    <= reduce_once(a0);
        a1_s1    <= reduce_once(a1);
        b0_s1    <= reduce_once(b0);
        b1_s1    <= reduce_once(b1);
        gamma_s1 <= gamma_rom[pair_cnt];
        idx_s1   <= pair_cnt;
        pair_cnt <= pair_cnt + 7'd1;
      end

      v2 <= v1;
      if (v1) begin
        p00_s2   <= p00;
        p11m_s2  <= p11_mod;
        sum1_s2  <= sum1_s1;
        gamma_s2 <= gamma_s1;
        idx_s2   <= idx_s1;
      end

      out_valid <= v2;
      if (v2) begin
        c0       <= c0_next;
        c1       <= c1_next;
        out_idx  <= idx_s2;
        out_last <= (idx_s2 == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_ntt_basemul.sv
// Self-checking bench for ntt_basemul. A negedge monitor keeps a scoreboard:
// every accepted input pushes the expected result computed by a small
// integer model, and every output transfer pops and compares.
module tb_ntt_basemul;

  localparam int QM = 3329;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a0, a1, b0, b1;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] c0, c1;
  logic [6:0]  out_idx;
  logic        out_last;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   exp_cnt;
  int   gamma_tb[128];

  ntt_basemul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c0        (c0),
    .c1        (c1),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rev7(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int k = 0; k < 7; k++) begin
      r = (r << 1) | (x & 1);
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic exp_t model(input int x0, input int x1, input int y0,
                                 input int y1, input int idx);
    exp_t   e;
    longint r0, r1, s0, s1;
    if (x0 >= QM) x0 -= QM;
    if (x1 >= QM) x1 -= QM;
    if (y0 >= QM) y0 -= QM;
    if (y1 >= QM) y1 -= QM;
    r0 = longint'(x0) * y0 + longint'(x1) * y1 * gamma_tb[idx];
    r1 = longint'(x0) * y1 + longint'(x1) * y0;
    s0 = r0 % QM;
    s1 = r1 % QM;
    e.c0   = 12'(s0);
    e.c1   = 12'(s1);
    e.idx  = 7'(idx);
    e.last = (idx == 127);
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got c0=%0d c1=%0d idx=%0d but no output expected",
                   c0, c1, out_idx);
        end else begin
          e = sb_q.pop_front();
          if (c0 !== e.c0 || c1 !== e.c1 || out_idx !== e.idx || out_last !== e.last) begin
            failures++;
            $display("FAIL sb_data: got c0=%0d c1=%0d idx=%0d last=%0b, expected c0=%0d c1=%0d idx=%0d last=%0b",
                     c0, c1, out_idx, out_last, e.c0, e.c1, e.idx, e.last);
          end
        end
      end
      if (clr) begin
        sb_q.delete();
        exp_cnt = 0;
      end else if (in_valid && in_ready) begin
        sb_q.push_back(model(int'(a0), int'(a1), int'(b0), int'(b1), exp_cnt));
        exp_cnt = (exp_cnt + 1) % 128;
      end
    end
  end

  task automatic drive_pair(input int x0, input int x1, input int y0, input int y1);
    in_valid = 1'b1;
    a0 = 12'(x0);
    a1 = 12'(x1);
    b0 = 12'(y0);
    b1 = 12'(y1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: out_valid=%0b busy=%0b out_last=%0b, expected 0 0 0",
               out_valid, busy, out_last);
    end
    checks++;
    if (c0 !== 12'd0 || c1 !== 12'd0 || out_idx !== 7'd0) begin
      failures++;
      $display("FAIL reset_data: c0=%0d c1=%0d out_idx=%0d, expected 0 0 0", c0, c1, out_idx);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    drive_pair(1, 1, 1, 1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_early1: out_valid=%0b expected 0", out_valid);
    end
    drive_pair(1, 1, 1, 1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_early2: out_valid=%0b expected 0", out_valid);
    end
    drive_pair(4000, 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || c0 !== 12'd18 || c1 !== 12'd2 || out_idx !== 7'd0) begin
      failures++;
      $display("FAIL pair0: valid=%0b c0=%0d c1=%0d idx=%0d, expected 1 18 2 0",
               out_valid, c0, c1, out_idx);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || c0 !== 12'd3313 || c1 !== 12'd2 || out_idx !== 7'd1) begin
      failures++;
      $display("FAIL pair1: valid=%0b c0=%0d c1=%0d idx=%0d, expected 1 3313 2 1",
               out_valid, c0, c1, out_idx);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || c0 !== 12'd671 || c1 !== 12'd0 || out_idx !== 7'd2) begin
      failures++;
      $display("FAIL pair2_reduce: valid=%0b c0=%0d c1=%0d idx=%0d, expected 1 671 0 2",
               out_valid, c0, c1, out_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: %0d results outstanding, busy=%0b, expected 0 and 0",
               name, sb_q.size(), busy);
    end
  endtask

  task automatic test_stream();
    int outs;
    int lasts;
    out_ready = 1'b1;
    outs = 0;
    lasts = 0;
    // Counter currently at 3: 130 pairs cross 127 and wrap to 0.
    for (int i = 0; i < 130; i++) begin
      drive_pair($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095));
      @(posedge clk); #1;
      if (out_valid) outs++;
      if (out_valid && out_last) lasts++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid) outs++;
      if (out_valid && out_last) lasts++;
    end
    checks++;
    if (outs != 130) begin
      failures++;
      $display("FAIL stream_throughput: got %0d output cycles expected 130", outs);
    end
    checks++;
    if (lasts != 1) begin
      failures++;
      $display("FAIL stream_last_count: got %0d expected 1", lasts);
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    logic        stalled;
    logic [11:0] s_c0, s_c1;
    logic [6:0]  s_idx;
    logic        s_last;
    stalled = 1'b0;
    s_c0 = '0; s_c1 = '0; s_idx = '0; s_last = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || c0 !== s_c0 || c1 !== s_c1 || out_idx !== s_idx ||
            out_last !== s_last) begin
          failures++;
          $display("FAIL stall_stable: valid=%0b c0=%0d c1=%0d idx=%0d, held c0=%0d c1=%0d idx=%0d",
                   out_valid, c0, c1, out_idx, s_c0, s_c1, s_idx);
        end
      end
      drive_pair($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++;
        $display("FAIL in_ready_rule: in_ready=%0b with out_valid=%0b out_ready=%0b",
                 in_ready, out_valid, out_ready);
      end
      stalled = out_valid && !out_ready;
      s_c0 = c0; s_c1 = c1; s_idx = out_idx; s_last = out_last;
    end
    drain("bp");
  endtask

  task automatic test_clr();
    int n;
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive_pair(5, 6, 7, 8);
    @(posedge clk); #1;
    drive_pair(9, 10, 11, 12);
    @(posedge clk); #1;
    drive_pair(13, 14, 15, 16);
    @(posedge clk); #1;
    drive_pair(100, 200, 300, 400);
    out_ready = 1'b1;
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup: busy=%0b out_valid=%0b in_ready=%0b, expected 1 1 1",
               busy, out_valid, in_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_flush: out_valid=%0b busy=%0b, expected 0 0", out_valid, busy);
    end
    drive_pair(2, 3, 4, 5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 7'd0) begin
      failures++;
      $display("FAIL clr_idx: out_valid=%0b out_idx=%0d, expected 1 0", out_valid, out_idx);
    end
    drain("clr");
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive_pair($urandom_range(1, 4095), $urandom_range(1, 4095),
                 $urandom_range(1, 4095), $urandom_range(1, 4095));
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup: out_valid=%0b busy=%0b, expected 1 1", out_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || c0 !== 12'd0 || c1 !== 12'd0 ||
        out_idx !== 7'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%0b busy=%0b c0=%0d c1=%0d idx=%0d last=%0b, expected all 0",
               out_valid, busy, c0, c1, out_idx, out_last);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_pair(1, 1, 1, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || c0 !== 12'd18 || c1 !== 12'd2 || out_idx !== 7'd0) begin
      failures++;
      $display("FAIL rstmid_first: valid=%0b c0=%0d c1=%0d idx=%0d, expected 1 18 2 0",
               out_valid, c0, c1, out_idx);
    end
    drain("rstmid");
  endtask

  initial begin
    int zeta[256];
    checks = 0;
    failures = 0;
    exp_cnt = 0;
    zeta[0] = 1;
    for (int k = 1; k < 256; k++) zeta[k] = (zeta[k-1] * 17) % QM;
    for (int i = 0; i < 128; i++) gamma_tb[i] = zeta[2 * rev7(i) + 1];

    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_clr();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
